// File: rtl/a51_pkg.sv
// Shared constants, register geometry and helpers for the A5/1 backward search.
package a51_pkg;

    localparam int StateWidth = 64;
    localparam int MaxSteps   = 100;
    localparam int CntWidth   = 7;
    localparam int FoundWidth = 16;
    localparam int NumRegs    = 3;

    // next_opt runs 0..3 for untried options; 4 marks an exhausted node
    localparam int OptWidth = 3;
    localparam logic [OptWidth-1:0] OptLast = 3'd3;
    localparam logic [OptWidth-1:0] OptDone = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_EMIT,
        ST_POP,
        ST_DONE
    } fsm_t;

    // Register geometry, index 0 = R1, 1 = R2, 2 = R3
    function automatic int reg_len(input int i);
        case (i)
            0:       return 19;
            1:       return 22;
            default: return 23;
        endcase
    endfunction

    function automatic int reg_lo(input int i);
        case (i)
            0:       return 0;
            1:       return 19;
            default: return 41;
        endcase
    endfunction

    function automatic int reg_clk(input int i);
        case (i)
            0:       return 8;
            default: return 10;
        endcase
    endfunction

    function automatic logic [22:0] reg_taps(input int i);
        case (i)
            0:       return 23'h072000;   // bits 18,17,16,13
            1:       return 23'h300000;   // bits 21,20
            default: return 23'h700080;   // bits 22,21,20,7
        endcase
    endfunction

    // Which registers each option un-shifts; bit 0 = R1
    function automatic logic [2:0] opt_mask(input logic [1:0] opt);
        case (opt)
            2'd0:    return 3'b111;
            2'd1:    return 3'b011;
            2'd2:    return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    // Undo one shift of a len-bit register held zero-extended in 23 bits.
    // The bit that fell off the top is recovered from the feedback equation.
    function automatic logic [22:0] unshift(input logic [22:0] r,
                                            input logic [22:0] taps,
                                            input int len);
        logic [22:0] o;
        logic        fb;
        o  = r >> 1;
        fb = r[0] ^ (^(o & taps));
        return o | (23'(fb) << (len - 1));
    endfunction

endpackage

// File: rtl/a51_reverse_if.sv
// Request / candidate-stream bundle of the backward search.
interface a51_reverse_if;
    import a51_pkg::*;

    logic                  start;
    logic [StateWidth-1:0] in_state;
    logic [CntWidth-1:0]   steps;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [StateWidth-1:0] out_state;
    logic                  done;
    logic [FoundWidth-1:0] found;

    modport master (
        output start, in_state, steps, out_ready,
        input  busy, out_valid, out_state, done, found
    );

    modport slave (
        input  start, in_state, steps, out_ready,
        output busy, out_valid, out_state, done, found
    );

endinterface

// File: rtl/a51_unstep.sv
// Combinational reverse of one majority clock for a single option.
module a51_unstep
    import a51_pkg::*;
(
    input  logic [StateWidth-1:0] cur,
    input  logic [1:0]            opt,
    output logic [StateWidth-1:0] cand,
    output logic                  valid
);

    logic [2:0] mask;
    logic [2:0] ck;
    logic [2:0] agree;
    logic       maj;

    assign mask = opt_mask(opt);

    // Per register: un-shift if selected, then expose its clock bit
    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
        localparam int          Len    = reg_len(gi);
        localparam int          Lo     = reg_lo(gi);
        localparam int          ClkBit = reg_clk(gi);
        localparam logic [22:0] Taps   = reg_taps(gi);

        logic [Len-1:0] reg_cur;
        logic [Len-1:0] reg_back;
        logic [Len-1:0] reg_new;

        assign reg_cur         = cur[Lo +: Len];
        assign reg_back        = Len'(unshift(23'(reg_cur), Taps, Len));
        assign reg_new         = mask[gi] ? reg_back : reg_cur;
        assign cand[Lo +: Len] = reg_new;
        assign ck[gi]          = reg_new[ClkBit];
        assign agree[gi]       = (ck[gi] == maj);
    end

    assign maj = (ck[0] & ck[1]) | (ck[0] & ck[2]) | (ck[1] & ck[2]);

    // The candidate would clock exactly the option's registers going forward
    assign valid = (agree == mask);

endmodule

// File: rtl/a51_reverse.sv
// Depth-first enumeration of A5/1 predecessors `steps` clocks back.
module a51_reverse
    import a51_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    a51_reverse_if.slave bus
);

    fsm_t                  state_reg, state_next;
    logic [CntWidth-1:0]   depth_reg, depth_next;
    logic [CntWidth-1:0]   steps_reg, steps_next;
    logic [OptWidth-1:0]   opt_top_reg, opt_top_next;
    logic [FoundWidth-1:0] found_reg, found_next;

    // Stack: states per level, and saved next_opt of the levels below the top.
    // The top level's next_opt lives in opt_top_reg so a push needs one write each.
    logic [StateWidth-1:0] stack_state [0:MaxSteps];
    logic [OptWidth-1:0]   stack_opt   [0:MaxSteps];

    logic                  st_we;
    logic [CntWidth-1:0]   st_waddr;
    logic [StateWidth-1:0] st_wdata;
    logic                  op_we;
    logic [CntWidth-1:0]   op_waddr;
    logic [OptWidth-1:0]   op_wdata;

    logic [StateWidth-1:0] top_state;
    logic [StateWidth-1:0] cand_state;
    logic                  cand_valid;
    logic [OptWidth-1:0]   below_opt;
    logic [CntWidth-1:0]   depth_inc;
    logic [CntWidth-1:0]   depth_dec;
    logic [CntWidth-1:0]   steps_clamped;

    assign depth_inc     = depth_reg + CntWidth'(1);
    assign depth_dec     = depth_reg - CntWidth'(1);
    assign steps_clamped = (bus.steps > CntWidth'(MaxSteps)) ? CntWidth'(MaxSteps) : bus.steps;
    assign top_state     = stack_state[depth_reg];
    assign below_opt     = stack_opt[depth_dec];

    a51_unstep u_unstep (
        .cur   (top_state),
        .opt   (opt_top_reg[1:0]),
        .cand  (cand_state),
        .valid (cand_valid)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            depth_reg   <= '0;
            steps_reg   <= '0;
            opt_top_reg <= '0;
            found_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            depth_reg   <= depth_next;
            steps_reg   <= steps_next;
            opt_top_reg <= opt_top_next;
            found_reg   <= found_next;
        end
    end

    // Stack storage writes
    always_ff @(posedge clk) begin
        if (st_we) stack_state[st_waddr] <= st_wdata;
        if (op_we) stack_opt[op_waddr]   <= op_wdata;
    end

    // Search sequencing: one option tested per EXPAND cycle
    always_comb begin
        state_next   = state_reg;
        depth_next   = depth_reg;
        steps_next   = steps_reg;
        opt_top_next = opt_top_reg;
        found_next   = found_reg;
        st_we        = 1'b0;
        st_waddr     = '0;
        st_wdata     = '0;
        op_we        = 1'b0;
        op_waddr     = '0;
        op_wdata     = '0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    st_we        = 1'b1;
                    st_wdata     = bus.in_state;
                    depth_next   = '0;
                    opt_top_next = '0;
                    found_next   = '0;
                    steps_next   = steps_clamped;
                    state_next   = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (depth_reg == steps_reg) begin
                    state_next = ST_EMIT;
                end else if (cand_valid) begin
                    op_we        = 1'b1;
                    op_waddr     = depth_reg;
                    op_wdata     = opt_top_reg + OptWidth'(1);
                    st_we        = 1'b1;
                    st_waddr     = depth_inc;
                    st_wdata     = cand_state;
                    opt_top_next = '0;
                    depth_next   = depth_inc;
                    if (depth_inc == steps_reg) state_next = ST_EMIT;
                end else begin
                    opt_top_next = opt_top_reg + OptWidth'(1);
                    if (opt_top_reg == OptLast) state_next = ST_POP;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (found_reg != '1) found_next = found_reg + FoundWidth'(1);
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                if (depth_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    depth_next   = depth_dec;
                    opt_top_next = below_opt;
                    state_next   = (below_opt == OptDone) ? ST_POP : ST_EXPAND;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.out_valid = (state_reg == ST_EMIT);
    assign bus.out_state = (state_reg == ST_EMIT) ? top_state : '0;
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.found     = found_reg;

endmodule

// File: tb/tb_a51_reverse.sv
// Scoreboard bench for a51_reverse against a bit-level software DFS.
module tb_a51_reverse;
    import a51_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a51_reverse_if bus ();

    a51_reverse dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    // Forward majority clock, written directly from the register definitions
    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic m;
        r1 = s[18:0];
        r2 = s[40:19];
        r3 = s[63:41];
        m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        if (r1[8] == m)  r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
        if (r2[10] == m) r2 = {r2[20:0], r2[21] ^ r2[20]};
        if (r3[10] == m) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
        return {r3, r2, r1};
    endfunction

    // One predecessor candidate for option o, with its validity
    function automatic logic [63:0] m_pre(input logic [63:0] s, input int o, output bit ok);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic [2:0] u;
        logic m;
        logic [63:0] c;
        r1 = s[18:0];
        r2 = s[40:19];
        r3 = s[63:41];
        case (o)
            0: u = 3'b111;
            1: u = 3'b011;
            2: u = 3'b101;
            default: u = 3'b110;
        endcase
        if (u[0]) r1 = {r1[0] ^ r1[18] ^ r1[17] ^ r1[14], r1[18:1]};
        if (u[1]) r2 = {r2[0] ^ r2[21], r2[21:1]};
        if (u[2]) r3 = {r3[0] ^ r3[22] ^ r3[21] ^ r3[8], r3[22:1]};
        m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        c = {r3, r2, r1};
        ok = ({r3[10] == m, r2[10] == m, r1[8] == m} == u) && (m_step(c) == s);
        return c;
    endfunction

    // Iterative DFS in option order; leaves pushed to exp_q, count returned
    function automatic int m_dfs(input logic [63:0] s, input int n);
        logic [63:0] st [0:100];
        int op [0:100];
        int d;
        int cnt;
        bit ok;
        logic [63:0] c;
        d = 0;
        cnt = 0;
        st[0] = s;
        op[0] = 0;
        while (1) begin
            if (d == n) begin
                exp_q.push_back(st[d]);
                cnt++;
                if (d == 0) break;
                d--;
            end else if (op[d] < 4) begin
                c = m_pre(st[d], op[d], ok);
                op[d]++;
                if (ok) begin
                    d++;
                    st[d] = c;
                    op[d] = 0;
                end
            end else begin
                if (d == 0) break;
                d--;
            end
        end
        return cnt;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Launch a search, score every accepted candidate, then check completion
    task automatic run_search(input string name, input logic [63:0] s, input int n_in,
                              input int ready_pct, input bit hold, input bit inject,
                              input bit want_have, input logic [63:0] have);
        int n_model;
        int exp_cnt;
        int emitted;
        bit timed_out;
        bit seen;
        bit held;
        bit stable;
        logic [63:0] hs;
        logic [15:0] hf;
        logic [63:0] e;
        n_model = (n_in > MaxSteps) ? MaxSteps : n_in;
        exp_q.delete();
        exp_cnt = m_dfs(s, n_model);
        emitted = 0;
        seen = 0;
        held = 0;
        timed_out = 1;
        @(negedge clk);
        bus.in_state = s;
        bus.steps = 7'(n_in);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_state = rand64();
        bus.steps = 7'($urandom_range(127));
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%b want=1", name, bus.busy);
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (bus.done === 1'b1) begin
                timed_out = 0;
                break;
            end
            if (inject && cyc == 2) begin
                bus.start = 1'b1;
                bus.in_state = ~s;
                bus.steps = 7'd0;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (hold && !held) begin
                    held = 1;
                    stable = 1;
                    hs = bus.out_state;
                    hf = bus.found;
                    bus.out_ready = 1'b0;
                    repeat (20) begin
                        @(negedge clk);
                        if (!(bus.out_valid === 1'b1 && bus.out_state === hs && bus.found === hf))
                            stable = 0;
                    end
                    total++;
                    if (!stable) begin
                        bad++;
                        $display("FAIL %s hold_stable valid=%b state=%h found=%0d want state=%h found=%0d",
                                 name, bus.out_valid, bus.out_state, bus.found, hs, hf);
                    end
                    continue;
                end
                bus.out_ready = ($urandom_range(99) < ready_pct);
                if (bus.out_ready) begin
                    emitted++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra_output got=%h want=none", name, bus.out_state);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_state !== e) begin
                            bad++;
                            $display("FAIL %s out_state#%0d got=%h want=%h", name, emitted, bus.out_state, e);
                        end
                    end
                    if (bus.out_state === have) seen = 1;
                    $display("%s xfer %0d state=%h", name, emitted, bus.out_state);
                end
            end else begin
                bus.out_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s done_timeout got=no_done want=done", name);
        end
        total++;
        if (bus.found !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL %s found got=%0d want=%0d", name, bus.found, exp_cnt);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing_outputs got=%0d want=0 left", name, exp_q.size());
        end
        if (want_have) begin
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL %s origin_emitted got=0 want=1 (%h)", name, have);
            end
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done done=%b busy=%b want 0/0", name, bus.done, bus.busy);
        end
        $display("%s search steps=%0d found=%0d expected=%0d", name, n_in, bus.found, exp_cnt);
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy, bus.out_valid, bus.done} !== 3'b000 || bus.out_state !== 64'h0 || bus.found !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b valid=%b done=%b state=%h found=%0d want all 0",
                     bus.busy, bus.out_valid, bus.done, bus.out_state, bus.found);
        end
    endtask

    task automatic test_zero_state();
        run_search("zero5", 64'h0, 5, 100, 0, 0, 1, 64'h0);
        total++;
        if (bus.found !== 16'd0) begin
            // found was checked at done; here it must be still held at 1
            if (bus.found !== 16'd1) begin
                bad++;
                $display("FAIL zero5_found_hold got=%0d want=1", bus.found);
            end
        end else begin
            bad++;
            $display("FAIL zero5_found_hold got=0 want=1");
        end
    endtask

    task automatic test_steps_zero();
        logic [63:0] s;
        s = rand64();
        run_search("steps0", s, 0, 70, 0, 0, 1, s);
    endtask

    task automatic test_one_step();
        logic [63:0] s;
        for (int i = 0; i < 4; i++) begin
            s = rand64();
            run_search("one_step", m_step(s), 1, 60, 0, 0, 1, s);
        end
    endtask

    task automatic test_deep();
        logic [63:0] s;
        logic [63:0] t;
        for (int i = 0; i < 2; i++) begin
            s = rand64();
            t = s;
            for (int k = 0; k < 100; k++) t = m_step(t);
            run_search("deep100", t, 100, 80, 0, 0, 1, s);
        end
    endtask

    task automatic test_clamp();
        logic [63:0] s;
        logic [63:0] t;
        s = rand64();
        t = s;
        for (int k = 0; k < 100; k++) t = m_step(t);
        run_search("clamp127", t, 127, 100, 0, 0, 1, s);
    endtask

    task automatic test_zero_pred();
        logic [63:0] t;
        int c;
        t = rand64();
        for (int i = 0; i < 200; i++) begin
            t = rand64();
            exp_q.delete();
            c = m_dfs(t, 1);
            if (c == 0) break;
        end
        exp_q.delete();
        run_search("zero_pred", t, 1, 100, 0, 0, 0, 64'h0);
    endtask

    task automatic test_backpressure();
        logic [63:0] s;
        s = rand64();
        run_search("hold", m_step(m_step(m_step(s))), 3, 100, 1, 0, 1, s);
    endtask

    task automatic test_start_busy();
        logic [63:0] s;
        logic [63:0] t;
        s = rand64();
        t = s;
        for (int k = 0; k < 100; k++) t = m_step(t);
        run_search("start_busy", t, 100, 100, 0, 1, 1, s);
    endtask

    task automatic test_reset_mid();
        logic [63:0] s;
        logic [63:0] t;
        s = rand64();
        t = s;
        for (int k = 0; k < 100; k++) t = m_step(t);
        @(negedge clk);
        bus.in_state = t;
        bus.steps = 7'd100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.out_valid, bus.done} !== 3'b000 || bus.out_state !== 64'h0 || bus.found !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid busy=%b valid=%b done=%b state=%h found=%0d want all 0",
                     bus.busy, bus.out_valid, bus.done, bus.out_state, bus.found);
        end
        $display("reset_mid asserted busy=%b", bus.busy);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_search("after_reset", t, 100, 90, 0, 0, 1, s);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_state = '0;
        bus.steps = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_zero_state();
        test_steps_zero();
        test_one_step();
        test_zero_pred();
        test_backpressure();
        test_deep();
        test_clamp();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
